// File: rtl/hs_pkg.sv
// Shared constants and types for the two-phase handshake receiver.
// Build option: HS_RX_SYNC3_EN selects a 3-flop request synchroniser (default 2).
package hs_pkg;

    localparam int HS_DATA_W = 3;

`ifdef HS_RX_SYNC3_EN
    localparam int HS_SYNC_STAGES = 3;
`else
    localparam int HS_SYNC_STAGES = 2;
`endif

    typedef logic [HS_DATA_W-1:0] hs_data_t;

endpackage

// File: rtl/hs_sync.sv
// N-flop bit synchroniser, asynchronous active-low reset to 0.
module hs_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/hs_rx_sink.sv
// Clocked sink for a two-phase bundled-data handshake: synchronises the
// request, captures data into a small FIFO, toggles the acknowledge and
// presents entries on a valid/ready stream.
// Build option: HS_RX_SYNC3_EN (3-flop request synchroniser, see hs_pkg).
module hs_rx_sink
    import hs_pkg::*;
#(
    parameter int DATA_W = HS_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_in,
    input  logic [DATA_W-1:0]          data_in,
    output logic                       ack_out,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic              req_s;
    logic              pending;
    logic              full;
    logic              wr_en;
    logic              rd_en;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    hs_sync #(.STAGES(HS_SYNC_STAGES)) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (req_in),
        .q     (req_s)
    );

    // A token is outstanding whenever the synchronised request and our ack differ.
    // Full is taken from the registered level, so a read at full frees the
    // slot only for the following edge (no pass-through).
    assign pending   = req_s != ack_out;
    assign full      = level == LW'(DEPTH);
    assign out_valid = level != '0;
    assign wr_en     = pending && !full;
    assign rd_en     = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    // Storage is deliberately not reset; contents are qualified by level.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy and acknowledge toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ack_out <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr  <= wr_ptr + AW'(1);
                ack_out <= ~ack_out;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !rd_en) begin
                level <= level + LW'(1);
            end else if (rd_en && !wr_en) begin
                level <= level - LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hs_rx_sink.sv
// Directed self-checking bench for hs_rx_sink.
module tb_hs_rx_sink;
    import hs_pkg::*;

    localparam int N = HS_SYNC_STAGES;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_in;
    logic [2:0] data_in;
    logic       ack_out;
    logic       out_valid;
    logic [2:0] out_data;
    logic       out_ready;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

    hs_rx_sink #(.DATA_W(3), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .data_in   (data_in),
        .ack_out   (ack_out),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_in    = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Send one token and wait (bounded) for the matching ack toggle.
    task automatic send(input logic [2:0] d, input string tag);
        bit got_ack;
        data_in = d;
        req_in  = ~req_in;
        got_ack = 1'b0;
        for (int i = 0; i < 12 && !got_ack; i++) begin
            tick();
            if (ack_out === req_in) got_ack = 1'b1;
        end
        check(tag, {31'b0, got_ack}, 32'd1);
    endtask

    initial begin
        int nread;
        int cyc;
        int nsent;
        int maxlvl;

        // ---- reset values ----
        do_reset();
        check("rst_ack", ack_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);

        // ---- single token: ack on edge N+1 ----
        data_in = 3'd5;
        req_in  = 1'b1;
        for (int e = 1; e <= N; e++) begin
            tick();
            check("single_ack_early", ack_out, 0);
            check("single_valid_early", out_valid, 0);
        end
        tick();
        check("single_ack", ack_out, 1);
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 5);
        check("single_level", level, 1);

        // ---- fill and stall ----
        do_reset();
        for (int t = 1; t <= 4; t++) send(3'(t), "fill_ack");
        check("fill_level", level, 4);
        check("fill_ack_val", ack_out, 0);
        data_in = 3'd5;
        req_in  = ~req_in;
        repeat (10) tick();
        check("stall_ack", ack_out, 0);
        check("stall_level", level, 4);
        check("stall_head", out_data, 1);
        out_ready = 1'b1;
        nread = 0;
        for (int c = 0; c < 40 && nread < 5; c++) begin
            if (out_valid) begin
                nread++;
                check("drain_data", out_data, nread);
            end
            tick();
        end
        check("drain_count", nread, 5);
        check("drain_ack", ack_out, 1);
        check("drain_level", level, 0);

        // ---- stream 0..7 with out_ready=1 ----
        do_reset();
        out_ready = 1'b1;
        nsent = 1;
        data_in = 3'd0;
        req_in  = 1'b1;
        nread = 0;
        maxlvl = 0;
        cyc = 0;
        while (cyc < 100 && nread < 8) begin
            tick();
            cyc++;
            if (int'(level) > maxlvl) maxlvl = int'(level);
            if (out_valid) begin
                check("stream_data", out_data, nread);
                nread++;
            end
            if (ack_out === req_in && nsent < 8) begin
                data_in = 3'(nsent);
                req_in  = ~req_in;
                nsent++;
            end
        end
        check("stream_count", nread, 8);
        check("stream_level_max", maxlvl, 1);
        check("stream_rate", {31'b0, (cyc <= 8 * (N + 2) + 2)}, 1);

        // ---- full with simultaneous read ----
        do_reset();
        for (int t = 1; t <= 4; t++) send(3'(t), "full_fill_ack");
        data_in = 3'd6;
        req_in  = ~req_in;
        repeat (6) tick();
        check("full_level", level, 4);
        check("full_ack_hold", ack_out, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("full_rd_level", level, 3);
        check("full_rd_ack", ack_out, 0);
        check("full_rd_head", out_data, 2);
        tick();
        check("full_wr_level", level, 4);
        check("full_wr_ack", ack_out, 1);

        // ---- reset mid-stream ----
        do_reset();
        send(3'd1, "mid_ack1");
        send(3'd2, "mid_ack2");
        check("mid_level", level, 2);
        data_in = 3'd7;
        req_in  = 1'b1;
        rst_n   = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_ack", ack_out, 0);
        tick();
        rst_n = 1'b1;
        repeat (N + 1) tick();
        check("post_rst_ack", ack_out, 1);
        check("post_rst_data", out_data, 7);
        repeat (10) tick();
        check("post_rst_level", level, 1);
        check("post_rst_ack_hold", ack_out, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
